// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM/WB sequencer: FSM state encoding, datapath
// width defaults, and the data-segment base used to build DM addresses.
package mips_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  localparam logic [31:0] DATA_SEG_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_WB   = 2'd2
  } seq_state_t;

endpackage

// File: rtl/dm_timeout_counter.sv
// Cycle counter for an outstanding DM access; tc flags the last cycle the
// sequencer is willing to wait before aborting.
module dm_timeout_counter #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_W'(TIMEOUT - 1));

  // Saturates at the terminal count so a stalled enable never wraps around.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_wb_sequencer.sv
// MEM / write-back controller of the multi-cycle MIPS datapath: issues at most
// one DM access per instruction and drives the register-file write port.
import mips_mem_pkg::*;

module mem_wb_sequencer #(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_AW  = REG_AW_DEF,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic              memtoReg,
  input  logic              regWrite,
  input  logic [REG_AW-1:0] writeReg,
  input  logic [DATA_W-1:0] ALUresult,
  input  logic [DATA_W-1:0] storeData,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  input  logic              dm_ready,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              err_clr,
  output logic              align_err,
  output logic              cfg_err,
  output logic              timeout_err
);

  seq_state_t state, state_nxt;

  logic              accept;
  logic              is_cfg, is_mem, is_align;
  logic              go_mem, go_alu, ld_done, st_done;
  logic              set_cfg, set_align, set_to;
  logic              tc;

  logic              cap_memtoReg;
  logic              cap_regWrite;
  logic              cap_store;
  logic [REG_AW-1:0] cap_writeReg;
  logic [DATA_W-1:0] cap_alu;
  logic [DATA_W-1:0] wb_data;

  assign ex_ready = (state != ST_MEM);
  assign accept   = ex_valid & ex_ready;

  assign is_cfg   = (memRead & memWrite) | (memtoReg & ~memRead);
  assign is_mem   = memRead | memWrite;
  assign is_align = is_mem & (ALUresult[1:0] != 2'b00);

  // Write-back select (control_mux): DM data for loads, ALU result otherwise.
  assign wb_data  = cap_memtoReg ? dm_rdata : cap_alu;

  dm_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (go_mem),
    .en    (state == ST_MEM),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    go_mem    = 1'b0;
    go_alu    = 1'b0;
    ld_done   = 1'b0;
    st_done   = 1'b0;
    set_cfg   = 1'b0;
    set_align = 1'b0;
    set_to    = 1'b0;
    case (state)
      ST_IDLE, ST_WB: begin
        state_nxt = ST_IDLE;
        if (accept) begin
          if (is_cfg) begin
            set_cfg = 1'b1;
          end else if (is_align) begin
            set_align = 1'b1;
          end else if (is_mem) begin
            go_mem    = 1'b1;
            state_nxt = ST_MEM;
          end else begin
            go_alu    = 1'b1;
            state_nxt = ST_WB;
          end
        end
      end
      ST_MEM: begin
        // A ready arriving on the terminal-count cycle still completes.
        if (dm_ready) begin
          if (cap_store) begin
            st_done   = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            ld_done   = 1'b1;
            state_nxt = ST_WB;
          end
        end else if (tc) begin
          set_to    = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_memtoReg <= 1'b0;
      cap_regWrite <= 1'b0;
      cap_store    <= 1'b0;
      cap_writeReg <= '0;
      cap_alu      <= '0;
    end else if (accept) begin
      cap_memtoReg <= memtoReg;
      cap_regWrite <= regWrite;
      cap_store    <= memWrite;
      cap_writeReg <= writeReg;
      cap_alu      <= ALUresult;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= '0;
      dm_wdata <= '0;
    end else if (go_mem) begin
      dm_req   <= 1'b1;
      dm_we    <= memWrite;
      dm_addr  <= ALUresult;
      dm_wdata <= storeData;
    end else if (ld_done || st_done || set_to) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
    end
  end

  // rf_we is registered so it is high for exactly the WB cycle; $0 is never written.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= 1'b0;
      if (go_alu) begin
        rf_we    <= regWrite & (writeReg != '0);
        rf_waddr <= writeReg;
        rf_wdata <= ALUresult;
      end else if (ld_done) begin
        rf_we    <= cap_regWrite & (cap_writeReg != '0);
        rf_waddr <= cap_writeReg;
        rf_wdata <= wb_data;
      end
    end
  end

  // A new error on the clear cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      align_err   <= 1'b0;
      cfg_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      align_err   <= set_align | (align_err   & ~err_clr);
      cfg_err     <= set_cfg   | (cfg_err     & ~err_clr);
      timeout_err <= set_to    | (timeout_err & ~err_clr);
    end
  end

endmodule

// File: tb/tb_mem_wb_sequencer.sv
// Directed self-checking bench for mem_wb_sequencer: ALU write-back, store
// burst, load latency, error flags, timeout and asynchronous reset.
`timescale 1ns/1ps

module tb_mem_wb_sequencer;
  import mips_mem_pkg::*;

  localparam int DATA_W  = 32;
  localparam int REG_AW  = 5;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ex_valid, ex_ready;
  logic              memRead, memWrite, memtoReg, regWrite;
  logic [REG_AW-1:0] writeReg;
  logic [DATA_W-1:0] ALUresult, storeData;
  logic              dm_req, dm_we;
  logic [DATA_W-1:0] dm_addr, dm_wdata, dm_rdata;
  logic              dm_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              err_clr, align_err, cfg_err, timeout_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_wb_sequencer #(
    .DATA_W (DATA_W), .REG_AW (REG_AW), .TIMEOUT (TIMEOUT), .CNT_W (CNT_W)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .ex_valid (ex_valid), .ex_ready (ex_ready),
    .memRead (memRead), .memWrite (memWrite), .memtoReg (memtoReg),
    .regWrite (regWrite), .writeReg (writeReg),
    .ALUresult (ALUresult), .storeData (storeData),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata), .dm_ready (dm_ready),
    .rf_we (rf_we), .rf_waddr (rf_waddr), .rf_wdata (rf_wdata),
    .err_clr (err_clr), .align_err (align_err), .cfg_err (cfg_err),
    .timeout_err (timeout_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; memRead = 0; memWrite = 0; memtoReg = 0; regWrite = 0;
    writeReg = '0; ALUresult = '0; storeData = '0;
    dm_ready = 0; dm_rdata = '0; err_clr = 0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic m2r, input logic rw,
                       input logic [REG_AW-1:0] wreg, input logic [DATA_W-1:0] alu,
                       input logic [DATA_W-1:0] sd);
    ex_valid = 1; memRead = rd; memWrite = wr; memtoReg = m2r; regWrite = rw;
    writeReg = wreg; ALUresult = alu; storeData = sd;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    total++;
    if ({ex_ready, dm_req, dm_we, dm_addr, dm_wdata, rf_we, rf_waddr, rf_wdata,
         align_err, cfg_err, timeout_err} !== {1'b1, 2'b00, 64'h0, 1'b0, 5'd0, 32'h0, 3'b000})
      $display("FAIL reset_outputs got req=%0b we=%0b rf_we=%0b addr=%h rdy=%0b",
               dm_req, dm_we, rf_we, dm_addr, ex_ready);
    else passed++;
    rst_n = 1;
    tick();
  endtask

  task automatic test_alu_only();
    issue(0, 0, 0, 1, 5'd8, 32'h0000_00ff, 32'h0);
    total++;
    if (ex_ready !== 1'b1) $display("FAIL alu_ex_ready got %0b want 1", ex_ready); else passed++;
    tick();
    ex_valid = 0;
    total++;
    if ({rf_we, rf_waddr, rf_wdata, dm_req} !== {1'b1, 5'd8, 32'h0000_00ff, 1'b0})
      $display("FAIL alu_wb got we=%0b waddr=%0d wdata=%h req=%0b want 1/8/000000ff/0",
               rf_we, rf_waddr, rf_wdata, dm_req);
    else passed++;
    tick();
    total++;
    if (rf_we !== 1'b0) $display("FAIL alu_wb_one_cycle got %0b want 0", rf_we); else passed++;
  endtask

  task automatic test_back_to_back();
    issue(0, 0, 0, 1, 5'd3, 32'h1234_5678, 32'h0);
    tick();
    issue(0, 0, 0, 1, 5'd4, 32'hcafe_0001, 32'h0);
    total++;
    if ({ex_ready, rf_we, rf_waddr, rf_wdata} !== {1'b1, 1'b1, 5'd3, 32'h1234_5678})
      $display("FAIL b2b_first got rdy=%0b we=%0b waddr=%0d wdata=%h", ex_ready, rf_we, rf_waddr, rf_wdata);
    else passed++;
    tick();
    issue(0, 0, 0, 1, 5'd0, 32'hdead_beef, 32'h0);
    total++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hcafe_0001})
      $display("FAIL b2b_second got we=%0b waddr=%0d wdata=%h", rf_we, rf_waddr, rf_wdata);
    else passed++;
    tick();
    ex_valid = 0;
    total++;
    if ({rf_we, rf_waddr} !== {1'b0, 5'd0})
      $display("FAIL reg0_no_write got we=%0b waddr=%0d want 0/0", rf_we, rf_waddr);
    else passed++;
    tick();
  endtask

  task automatic test_store_burst();
    logic [DATA_W-1:0] fib [8];
    int bad = 0;
    fib = '{32'd1, 32'd2, 32'd3, 32'd5, 32'd8, 32'd13, 32'd21, 32'd34};
    for (int i = 0; i < 8; i++) begin
      logic [DATA_W-1:0] a;
      a = DATA_SEG_BASE + 32'(4 * (i + 1));
      issue(0, 1, 0, 0, 5'd0, a, fib[i]);
      tick();
      ex_valid = 0;
      for (int c = 0; c < 2; c++) begin
        total++;
        if ({dm_req, dm_we, dm_addr, dm_wdata, ex_ready, rf_we} !== {2'b11, a, fib[i], 2'b00}) begin
          $display("FAIL store_%0d_c%0d got req=%0b we=%0b addr=%h wdata=%h rdy=%0b rf_we=%0b want addr=%h wdata=%h",
                   i, c, dm_req, dm_we, dm_addr, dm_wdata, ex_ready, rf_we, a, fib[i]);
          bad++;
        end else passed++;
        if (c == 1) dm_ready = 1;
        tick();
      end
      dm_ready = 0;
      total++;
      if ({dm_req, rf_we, ex_ready} !== 3'b001)
        $display("FAIL store_%0d_done got req=%0b rf_we=%0b rdy=%0b", i, dm_req, rf_we, ex_ready);
      else passed++;
    end
  endtask

  task automatic test_load();
    issue(1, 0, 1, 1, 5'd9, DATA_SEG_BASE + 32'h24, 32'h0);
    tick();
    ex_valid = 0;
    total++;
    if ({dm_req, dm_we, dm_addr} !== {2'b10, DATA_SEG_BASE + 32'h24})
      $display("FAIL load_req got req=%0b we=%0b addr=%h", dm_req, dm_we, dm_addr);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (ex_ready !== 1'b0) $display("FAIL load_stall_c%0d got ex_ready=%0b want 0", c, ex_ready);
      else passed++;
      if (c == 2) begin dm_ready = 1; dm_rdata = 32'h0000_0037; end
      tick();
    end
    dm_ready = 0; dm_rdata = '0;
    total++;
    if ({rf_we, rf_waddr, rf_wdata, dm_req, ex_ready} !== {1'b1, 5'd9, 32'h37, 1'b0, 1'b1})
      $display("FAIL load_wb got we=%0b waddr=%0d wdata=%h req=%0b rdy=%0b",
               rf_we, rf_waddr, rf_wdata, dm_req, ex_ready);
    else passed++;
    tick();
    total++;
    if (rf_we !== 1'b0) $display("FAIL load_wb_one_cycle got %0b want 0", rf_we); else passed++;
  endtask

  task automatic test_errors();
    issue(1, 0, 1, 1, 5'd7, DATA_SEG_BASE + 32'h6, 32'h0);
    tick();
    ex_valid = 0;
    total++;
    if ({align_err, dm_req, rf_we, ex_ready, cfg_err} !== 5'b10010)
      $display("FAIL align_set got align=%0b req=%0b rf_we=%0b rdy=%0b cfg=%0b",
               align_err, dm_req, rf_we, ex_ready, cfg_err);
    else passed++;
    issue(0, 1, 0, 0, 5'd0, DATA_SEG_BASE + 32'h1, 32'h5);
    err_clr = 1;
    tick();
    ex_valid = 0;
    total++;
    if ({align_err, dm_req} !== 2'b10)
      $display("FAIL align_clr_vs_set got align=%0b req=%0b want 1/0", align_err, dm_req);
    else passed++;
    tick();
    err_clr = 0;
    total++;
    if (align_err !== 1'b0) $display("FAIL align_clr got %0b want 0", align_err); else passed++;
    issue(1, 1, 0, 0, 5'd0, DATA_SEG_BASE, 32'h0);
    tick();
    ex_valid = 0;
    total++;
    if ({cfg_err, dm_req, align_err} !== 3'b100)
      $display("FAIL cfg_rdwr got cfg=%0b req=%0b align=%0b", cfg_err, dm_req, align_err);
    else passed++;
    err_clr = 1;
    tick();
    err_clr = 0;
    issue(0, 0, 1, 1, 5'd5, 32'h3, 32'h0);
    tick();
    ex_valid = 0;
    total++;
    if ({cfg_err, align_err, rf_we, dm_req} !== 4'b1000)
      $display("FAIL cfg_m2r got cfg=%0b align=%0b rf_we=%0b req=%0b", cfg_err, align_err, rf_we, dm_req);
    else passed++;
    err_clr = 1;
    tick();
    err_clr = 0;
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    int rf_seen = 0;
    issue(1, 0, 1, 1, 5'd0, DATA_SEG_BASE + 32'h28, 32'h0);
    tick();
    ex_valid = 0;
    for (int c = 0; c < 40 && dm_req; c++) begin
      req_cycles++;
      if (rf_we) rf_seen++;
      tick();
    end
    total++;
    if (req_cycles != TIMEOUT) $display("FAIL timeout_len got %0d want %0d", req_cycles, TIMEOUT);
    else passed++;
    total++;
    if ({timeout_err, ex_ready, rf_we, dm_req} !== 4'b1100 || rf_seen != 0)
      $display("FAIL timeout_abort got to=%0b rdy=%0b rf_we=%0b req=%0b rf_seen=%0d",
               timeout_err, ex_ready, rf_we, dm_req, rf_seen);
    else passed++;
    err_clr = 1;
    tick();
    err_clr = 0;
    total++;
    if (timeout_err !== 1'b0) $display("FAIL timeout_clr got %0b want 0", timeout_err); else passed++;
  endtask

  task automatic test_ready_at_timeout();
    issue(1, 0, 1, 1, 5'd10, DATA_SEG_BASE + 32'h2c, 32'h0);
    tick();
    ex_valid = 0;
    for (int c = 1; c < TIMEOUT; c++) tick();
    total++;
    if (dm_req !== 1'b1) $display("FAIL ready_tc_req got %0b want 1", dm_req); else passed++;
    dm_ready = 1; dm_rdata = 32'h0000_abcd;
    tick();
    dm_ready = 0; dm_rdata = '0;
    total++;
    if ({rf_we, rf_waddr, rf_wdata, timeout_err, dm_req} !== {1'b1, 5'd10, 32'h0000_abcd, 2'b00})
      $display("FAIL ready_wins got we=%0b waddr=%0d wdata=%h to=%0b req=%0b",
               rf_we, rf_waddr, rf_wdata, timeout_err, dm_req);
    else passed++;
    tick();
  endtask

  task automatic test_async_reset();
    issue(1, 1, 0, 0, 5'd0, 32'h0, 32'h0);
    tick();
    issue(1, 0, 1, 1, 5'd11, DATA_SEG_BASE + 32'h30, 32'h0);
    tick();
    ex_valid = 0;
    total++;
    if ({dm_req, cfg_err, ex_ready} !== 3'b110)
      $display("FAIL rst_pre got req=%0b cfg=%0b rdy=%0b want 1/1/0", dm_req, cfg_err, ex_ready);
    else passed++;
    #2 rst_n = 0;
    #1;
    total++;
    if ({ex_ready, dm_req, dm_we, dm_addr, dm_wdata, rf_we, rf_waddr, rf_wdata,
         align_err, cfg_err, timeout_err} !== {1'b1, 2'b00, 64'h0, 1'b0, 5'd0, 32'h0, 3'b000})
      $display("FAIL async_reset got req=%0b addr=%h rf_wdata=%h cfg=%0b rdy=%0b",
               dm_req, dm_addr, rf_wdata, cfg_err, ex_ready);
    else passed++;
    #2 rst_n = 1;
    tick();
    total++;
    if ({dm_req, rf_we, ex_ready} !== 3'b001)
      $display("FAIL post_reset_idle got req=%0b rf_we=%0b rdy=%0b", dm_req, rf_we, ex_ready);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_back_to_back();
    test_store_burst();
    test_load();
    test_errors();
    test_timeout();
    test_ready_at_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d total=%0d", passed, total);
    $fatal(1, "watchdog");
  end

endmodule
